multi_pwm_generator: RTL and testbench
======================================

Name: multi_pwm_generator

Overview:
N-channel PWM generator sharing one period counter, for driving motor H-bridge half-legs and servos from a single block. It supersedes the single-channel generator with:
- Parametrised width and channel count.
- Edge-aligned or center-aligned counting.
- Double-buffered period/duty updates applied only at period boundaries.
- Complementary high/low outputs per channel with programmable dead time.

Parameters:
NUM_CH, 4, number of PWM channels
WIDTH, 16, width of counter, period and each duty value
DT_WIDTH, 8, width of dead-time value

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
en  input  1  run enable; low = idle (counter held, outputs low)
center_mode  input  1  0 = edge-aligned, 1 = center-aligned (sampled at boundary, like period)
period  input  WIDTH  requested period value (shadow input)
duty  input  NUM_CH*WIDTH  requested duty per channel, ch i at [i*WIDTH +: WIDTH]
dead_time  input  DT_WIDTH  dead band in clk cycles, sampled live
load  input  1  pulse: capture period/duty/center_mode into pending registers
pwm_hi  output  NUM_CH  high-side drive per channel
pwm_lo  output  NUM_CH  low-side (complementary) drive per channel
period_start  output  1  one-cycle pulse at start of each PWM period
load_pending  output  1  pending values captured, not yet applied

Behaviour:
- Reset: ctr=0, dir=up, active period/duty/mode=0, pending cleared, load_pending=0, pwm_hi=0, pwm_lo=0, period_start=0, all channels idle.
- Counter, edge mode: ctr counts 0..P, where P is the active period, then wraps to 0. Period length = P+1 cycles. If P=0, ctr stays 0 and every cycle is a boundary.
- Counter, center mode: ctr counts up 0..P, then down P-1..1, then returns to 0. Period length = 2P cycles. If P=0, behaviour is the same as edge mode with P=0.
- Terminal cycle:
  - edge mode: ctr==P.
  - center mode: dir=down and ctr==1, or P==0.
  - The next cycle has ctr=0 and is the boundary.
- Compare per channel: raw_i = (ctr < D_i), unsigned. D_i=0 means always low; D_i > P means always high.
- Shadow load:
  - load=1 copies period/duty/center_mode into pending registers and sets load_pending.
  - On a terminal cycle with load_pending=1 (or load=1 in that same cycle), the active registers take the pending values (or the load-cycle inputs) for the next period, and load_pending clears.
  - A load in a non-terminal cycle overwrites earlier pending values (last wins).
- en=0:
  - ctr=0, dir=up, outputs low, all channels idle, period_start=0.
  - Pending values are applied to the active registers immediately and load_pending clears.
  - load is still honoured.
  - On the en 0->1 transition, counting starts at ctr=0 in that cycle.
- period_start: registered; high for exactly one cycle, aligned with the output cycle derived from ctr=0 (including the first period after en rises).
- Output latency: outputs are registered. Output at cycle t+1 reflects raw at cycle t.
- Dead time, per channel:
  - State tracks the last raw value (or idle) and a down-counter.
  - On a raw change (leaving idle counts as a change), both pwm_hi and pwm_lo are forced low for dead_time cycles, using the dead_time value sampled at the change. After that, pwm_hi=raw or pwm_lo=~raw.
  - If raw changes again during the dead band, the counter restarts with the new target.
  - dead_time=0: pwm_hi = raw delayed 1 cycle, pwm_lo = ~raw delayed 1 cycle, with no gap.
  - Invariant: pwm_hi & pwm_lo is never 1, on any channel, in any cycle.
- rst mid-operation: return to the reset state on the next edge. Pending values are lost.

Test Plan:
- Edge, P=9, D0=3, dt=0, NUM_CH=4: pwm_hi[0] high for 3 of every 10 cycles and pwm_lo[0] high for 7, with no gap. period_start every 10 cycles, coincident with pwm_hi[0] rising.
- Center, P=5, D0=2, dt=0: ctr sequence 0,1,2,3,4,5,4,3,2,1 repeats. pwm_hi[0] high 3 of every 10 cycles (ctr 0,1,1), symmetric about ctr=0.
- Dead time: edge, P=9, D0=5, dt=2. Per period, pwm_hi[0]=3 cycles, pwm_lo[0]=3 cycles, and 2 all-low cycles at each transition. Assert hi&lo==0 throughout.
- Shadow update: mid-period load P=19, D0=10. The current period completes with P=9. load_pending stays 1 until the terminal cycle, then 0. The next period is 20 cycles with 10 high.
- Boundaries: D1=0 gives pwm_hi[1] always 0. D2=15 with P=9 gives pwm_hi[2] always 1 after the initial dead band. P=0 gives period_start every cycle.
- en/rst mid-period: drop en at ctr=4, which forces all outputs low and ctr=0. Raise en; the first rising output comes after dt cycles, then normal output. Asserting rst mid-period clears load_pending and all outputs on the next edge.

Source files
------------

// File: rtl/multi_pwm_generator.sv
// N-channel PWM (edge/center aligned) with shared counter, shadowed period/duty and per-channel dead time.
// Latency: outputs registered one cycle after the compare; no backpressure, free-running while en is high.
module multi_pwm_generator #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 16,
    parameter int DT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    center_mode,
    input  logic [WIDTH-1:0]        period,
    input  logic [NUM_CH*WIDTH-1:0] duty,
    input  logic [DT_WIDTH-1:0]     dead_time,
    input  logic                    load,
    output logic [NUM_CH-1:0]       pwm_hi,
    output logic [NUM_CH-1:0]       pwm_lo,
    output logic                    period_start,
    output logic                    load_pending
);

    logic [WIDTH-1:0]               ctr_q, ctr_d;
    logic                           dir_q, dir_d;     // 1 = counting down (center mode)
    logic [WIDTH-1:0]               per_q, per_d, pper_q, pper_d;
    logic [NUM_CH*WIDTH-1:0]        duty_q, duty_d, pduty_q, pduty_d;
    logic                           cmode_q, cmode_d, pcmode_q, pcmode_d;
    logic                           pend_q, pend_d;
    logic [NUM_CH-1:0]              raw;
    logic [NUM_CH-1:0]              last_q, last_d, idle_q, idle_d;
    logic [NUM_CH-1:0]              hi_q, hi_d, lo_q, lo_d;
    logic [NUM_CH-1:0][DT_WIDTH-1:0] dtc_q, dtc_d;
    logic                           ps_q, ps_d;
    logic                           term, apply;

    // P=1 in center mode never turns around, so its top is also the terminal cycle.
    always_comb begin
        if (cmode_q) begin
            term = (per_q == '0) ||
                   ((ctr_q == WIDTH'(1)) && (dir_q || (per_q == WIDTH'(1))));
        end else begin
            term = (ctr_q == per_q);
        end
    end

    always_comb begin
        ctr_d = ctr_q;
        dir_d = dir_q;
        if (!en || term) begin
            ctr_d = '0;
            dir_d = 1'b0;
        end else if (!cmode_q) begin
            ctr_d = ctr_q + WIDTH'(1);
        end else if (dir_q) begin
            ctr_d = ctr_q - WIDTH'(1);
        end else if (ctr_q == per_q) begin
            ctr_d = ctr_q - WIDTH'(1);
            dir_d = 1'b1;
        end else begin
            ctr_d = ctr_q + WIDTH'(1);
        end
    end

    // Pending values go live at a period boundary, or at once while idle.
    always_comb begin
        apply    = (pend_q || load) && (!en || term);
        per_d    = per_q;
        duty_d   = duty_q;
        cmode_d  = cmode_q;
        pper_d   = pper_q;
        pduty_d  = pduty_q;
        pcmode_d = pcmode_q;
        pend_d   = pend_q;
        if (load) begin
            pper_d   = period;
            pduty_d  = duty;
            pcmode_d = center_mode;
        end
        if (apply) begin
            per_d   = load ? period      : pper_q;
            duty_d  = load ? duty        : pduty_q;
            cmode_d = load ? center_mode : pcmode_q;
            pend_d  = 1'b0;
        end else if (load) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            raw[i] = (ctr_q < duty_q[i*WIDTH +: WIDTH]);
        end
    end

    // A change restarts the dead band; drive only once the band has expired.
    always_comb begin
        last_d = last_q;
        idle_d = idle_q;
        dtc_d  = dtc_q;
        hi_d   = '0;
        lo_d   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!en) begin
                idle_d[i] = 1'b1;
                last_d[i] = 1'b0;
                dtc_d[i]  = '0;
            end else begin
                if (idle_q[i] || (raw[i] != last_q[i])) begin
                    idle_d[i] = 1'b0;
                    last_d[i] = raw[i];
                    dtc_d[i]  = dead_time;
                end else if (dtc_q[i] != '0) begin
                    dtc_d[i] = dtc_q[i] - DT_WIDTH'(1);
                end
                hi_d[i] = (dtc_d[i] == '0) &&  raw[i];
                lo_d[i] = (dtc_d[i] == '0) && !raw[i];
            end
        end
        ps_d = en && (ctr_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q    <= '0;
            dir_q    <= 1'b0;
            per_q    <= '0;
            duty_q   <= '0;
            cmode_q  <= 1'b0;
            pper_q   <= '0;
            pduty_q  <= '0;
            pcmode_q <= 1'b0;
            pend_q   <= 1'b0;
            last_q   <= '0;
            idle_q   <= '1;
            dtc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ps_q     <= 1'b0;
        end else begin
            ctr_q    <= ctr_d;
            dir_q    <= dir_d;
            per_q    <= per_d;
            duty_q   <= duty_d;
            cmode_q  <= cmode_d;
            pper_q   <= pper_d;
            pduty_q  <= pduty_d;
            pcmode_q <= pcmode_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            idle_q   <= idle_d;
            dtc_q    <= dtc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            ps_q     <= ps_d;
        end
    end

    assign pwm_hi       = hi_q;
    assign pwm_lo       = lo_q;
    assign period_start = ps_q;
    assign load_pending = pend_q;

endmodule

// File: tb/tb_multi_pwm_generator.sv
// Scoreboard bench: a phase-based reference model predicts each output cycle; a monitor compares.
module tb_multi_pwm_generator;
    localparam int NUM_CH   = 4;
    localparam int WIDTH    = 16;
    localparam int DT_WIDTH = 8;

    logic                    clk = 1'b0;
    logic                    rst, en, center_mode, load;
    logic [WIDTH-1:0]        period;
    logic [NUM_CH*WIDTH-1:0] duty;
    logic [DT_WIDTH-1:0]     dead_time;
    logic [NUM_CH-1:0]       pwm_hi, pwm_lo;
    logic                    period_start, load_pending;

    always #5 clk = ~clk;

    multi_pwm_generator #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en), .center_mode(center_mode),
        .period(period), .duty(duty), .dead_time(dead_time), .load(load),
        .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
        .period_start(period_start), .load_pending(load_pending)
    );

    typedef struct {
        logic [NUM_CH-1:0] hi;
        logic [NUM_CH-1:0] lo;
        logic              ps;
        logic              lp;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model: position k within the period, active/pending settings,
    // and per channel the cycle of the last compare change with its dead time.
    int m_P, m_C, p_P, p_C, k, cyc;
    int m_D[NUM_CH];
    int p_D[NUM_CH];
    bit m_pend;
    bit idle[NUM_CH];
    bit last[NUM_CH];
    int chg_cyc[NUM_CH];
    int chg_dt[NUM_CH];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    function automatic int m_len();
        if (m_C != 0 && m_P > 0) return 2 * m_P;
        return m_P + 1;
    endfunction

    function automatic int m_ctr();
        if (m_C != 0 && k > m_P) return 2 * m_P - k;
        return k;
    endfunction

    task automatic take_inputs_active();
        m_P = int'(period);
        m_C = int'(center_mode);
        for (int i = 0; i < NUM_CH; i++) m_D[i] = int'(duty[i*WIDTH +: WIDTH]);
    endtask

    task automatic take_pending_active();
        m_P = p_P;
        m_C = p_C;
        for (int i = 0; i < NUM_CH; i++) m_D[i] = p_D[i];
    endtask

    task automatic model_step();
        exp_t e;
        int   ctr;
        bit   raw, act, term;
        e.hi = '0; e.lo = '0; e.ps = 1'b0; e.lp = 1'b0;
        if (rst) begin
            m_P = 0; m_C = 0; p_P = 0; p_C = 0; m_pend = 0; k = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_D[i] = 0; p_D[i] = 0; idle[i] = 1; last[i] = 0;
            end
        end else if (!en) begin
            if (load) take_inputs_active();
            else if (m_pend) take_pending_active();
            m_pend = 0;
            k = 0;
            for (int i = 0; i < NUM_CH; i++) idle[i] = 1;
        end else begin
            ctr  = m_ctr();
            e.ps = (k == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                raw = (ctr < m_D[i]);
                if (idle[i] || raw != last[i]) begin
                    chg_cyc[i] = cyc;
                    chg_dt[i]  = int'(dead_time);
                    last[i]    = raw;
                    idle[i]    = 0;
                end
                act = ((cyc - chg_cyc[i]) >= chg_dt[i]);
                e.hi[i] = act && raw;
                e.lo[i] = act && !raw;
            end
            term = (k == m_len() - 1);
            k = term ? 0 : k + 1;
            if (term && (m_pend || load)) begin
                if (load) take_inputs_active();
                else take_pending_active();
                m_pend = 0;
            end else if (load) begin
                p_P = int'(period);
                p_C = int'(center_mode);
                for (int i = 0; i < NUM_CH; i++) p_D[i] = int'(duty[i*WIDTH +: WIDTH]);
                m_pend = 1;
            end
            e.lp = m_pend;
        end
        cyc++;
        exp_q.push_back(e);
    endtask

    // Inputs are set after a falling edge; the model predicts the next registered output.
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_cfg(input int p, input int c, input int d0, input int d1, input int d2, input int d3);
        period      = WIDTH'(p);
        center_mode = (c != 0);
        duty[0*WIDTH +: WIDTH] = WIDTH'(d0);
        duty[1*WIDTH +: WIDTH] = WIDTH'(d1);
        duty[2*WIDTH +: WIDTH] = WIDTH'(d2);
        duty[3*WIDTH +: WIDTH] = WIDTH'(d3);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pwm_hi", 32'(pwm_hi), 32'(e.hi));
                chk("pwm_lo", 32'(pwm_lo), 32'(e.lo));
                chk("period_start", 32'(period_start), 32'(e.ps));
                chk("load_pending", 32'(load_pending), 32'(e.lp));
                chk("hi_and_lo_overlap", 32'(pwm_hi & pwm_lo), 32'd0);
            end
        end
    end

    initial begin
        int seg_len, ld_at, rp, rc, rd0, rd1, rd2, rd3;
        cyc = 0;
        rst = 1'b1; en = 1'b0; load = 1'b0; dead_time = '0;
        period = '0; center_mode = 1'b0; duty = '0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;

        // Edge P=9, channel duties 3 / 0 / 15 (> P) / 5, no dead time
        set_cfg(9, 0, 3, 0, 15, 5); load = 1'b1; tick(); load = 1'b0;
        en = 1'b1; repeat (40) tick();

        // Center P=5
        set_cfg(5, 1, 2, 1, 9, 0); load = 1'b1; tick(); load = 1'b0;
        repeat (40) tick();

        // Dead band of 2 on edge P=9, D0=5
        set_cfg(9, 0, 5, 0, 15, 5); dead_time = 8'd2; load = 1'b1; tick(); load = 1'b0;
        repeat (40) tick();

        // Mid-period shadow load: current period completes first
        repeat (3) tick();
        set_cfg(19, 0, 10, 0, 15, 5); load = 1'b1; tick(); load = 1'b0;
        repeat (60) tick();

        // P=0: every cycle is a boundary
        set_cfg(0, 0, 1, 0, 1, 0); dead_time = 8'd0; load = 1'b1; tick(); load = 1'b0;
        repeat (15) tick();

        // Drop en at ctr=4, restart with dead time 3
        set_cfg(9, 0, 5, 0, 15, 3); load = 1'b1; tick(); load = 1'b0;
        dead_time = 8'd3;
        for (int n = 0; n < 40 && !(k == 4 && m_P == 9); n++) tick();
        en = 1'b0; repeat (3) tick();
        en = 1'b1; repeat (30) tick();

        // rst mid-period with a load still pending
        repeat (4) tick();
        set_cfg(14, 1, 7, 2, 20, 0); load = 1'b1; tick(); load = 1'b0;
        repeat (2) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (5) tick();
        set_cfg(6, 1, 3, 6, 1, 0); load = 1'b1; tick(); load = 1'b0;
        repeat (30) tick();

        // Randomized segments: configs, load timing, dead time, en/rst glitches
        for (int s = 0; s < 40; s++) begin
            seg_len = int'($urandom_range(30, 70));
            ld_at   = int'($urandom_range(0, 29));
            rp  = int'($urandom_range(0, 12));
            rc  = int'($urandom_range(0, 1));
            rd0 = int'($urandom_range(0, 14));
            rd1 = int'($urandom_range(0, 14));
            rd2 = int'($urandom_range(0, 14));
            rd3 = int'($urandom_range(0, 14));
            for (int n = 0; n < seg_len; n++) begin
                if (n == ld_at) begin
                    set_cfg(rp, rc, rd0, rd1, rd2, rd3);
                    load = 1'b1;
                end
                if ($urandom_range(0, 9) == 0) dead_time = DT_WIDTH'($urandom_range(0, 3));
                en  = ($urandom_range(0, 29) != 0);
                rst = ($urandom_range(0, 199) == 0);
                tick();
                load = 1'b0;
                rst  = 1'b0;
            end
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
